// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port between the MEM stage of the pipeline
// (core) and an external loader/debug requester (ext). The core always wins
// a contested cycle. Ext is served in core-idle cycles, and a starvation
// counter forces one ext grant (stalling the whole pipeline for that cycle)
// once ext has been denied STARVE_LIM times in a row.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   core_rd/core_wr      MEM-stage read/write enables
//   core_addr/_wdata     MEM-stage address and store data
//   core_func3           MEM-stage load/store size code
//   core_rdata           load data back to MEM/WB (0 when core is not owner)
//   core_stall           freezes the pipeline for the forced ext cycle
//   ext_req              ext request, held until ext_ack
//   ext_we               ext direction, 1 = write
//   ext_addr/_wdata      ext address and write data
//   ext_func3            ext size code
//   ext_ack              registered one-cycle completion pulse
//   ext_rdata            ext read data, valid with ext_ack, held until next read
//   mem_rd/mem_wr        enables to datamemory
//   mem_addr/_wdata      address and write data to datamemory
//   mem_func3            size code to datamemory
//   mem_rdata            combinational read data from datamemory
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = $clog2(STARVE_LIM) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_func3,
  output logic                  ext_ack,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ext_ack_r;
  logic [DATA_W-1:0]   ext_rdata_r;

  logic                core_active_s;
  logic                ext_elig_s;
  logic                force_s;
  logic                ext_own_s;
  logic                denial_s;

  // Ownership decode: FORCE hands the port to ext unconditionally; otherwise
  // ext only gets cycles the core leaves idle. A request is not eligible in
  // its own ack cycle, which caps ext at one access every two cycles.
  always_comb begin
    core_active_s = core_rd | core_wr;
    ext_elig_s    = ext_req & ~ext_ack_r;
    force_s       = (state_r == ST_FORCE);
    ext_own_s     = force_s | (ext_elig_s & ~core_active_s);
    denial_s      = ext_elig_s & core_active_s & ~force_s;
  end

  // Memory-port mux and core-side returns; the core path stays combinational
  // so loads and stores see no extra pipeline latency.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_func3  = core_func3;
    core_rdata = {DATA_W{1'b0}};
    core_stall = 1'b0;
    if (ext_own_s) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_func3 = ext_func3;
      if (reset) begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end else begin
        mem_rd = ~ext_we;
        mem_wr = ext_we;
      end
    end else begin
      core_rdata = mem_rdata;
      if (reset) begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end else begin
        mem_rd = core_rd;
        mem_wr = core_wr;
      end
    end
    // The stall only exists in FORCE and is suppressed while reset is high.
    if (force_s && !reset) begin
      core_stall = 1'b1;
    end else begin
      core_stall = 1'b0;
    end
  end

  // Ext completion: ack one cycle after the grant; read data captured in the
  // grant cycle and held until the next ext read grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_ack_r   <= 1'b0;
      ext_rdata_r <= {DATA_W{1'b0}};
    end else begin
      ext_ack_r <= ext_own_s;
      if (ext_own_s && !ext_we) begin
        ext_rdata_r <= mem_rdata;
      end
    end
  end

  // Starvation FSM: counts consecutive denials and forces a grant on the
  // STARVE_LIM-th; any grant or dropped request restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (denial_s) begin
            state_r <= ST_WAIT;
            cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_WAIT: begin
          if (!ext_req || ext_own_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (denial_s) begin
            if (cnt_r == CNT_W'(STARVE_LIM - 1)) begin
              state_r <= ST_FORCE;
              cnt_r   <= cnt_r;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= cnt_r;
          end
        end
        ST_FORCE: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign ext_ack   = ext_ack_r;
  assign ext_rdata = ext_rdata_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
  localparam int STARVE_LIM = 4;

  logic                  clk;
  logic                  reset;
  logic                  core_rd, core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_func3;
  logic [DATA_W-1:0]     core_rdata;
  logic                  core_stall;
  logic                  ext_req, ext_we;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [2:0]            ext_func3;
  logic                  ext_ack;
  logic [DATA_W-1:0]     ext_rdata;
  logic                  mem_rd, mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Word-addressed memory model behind the port.
  logic [DATA_W-1:0] mem [0:127];
  logic              tb_clear;
  logic              tb_load;
  logic [6:0]        tb_load_idx;
  logic [DATA_W-1:0] tb_load_val;

  assign mem_rdata = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
    end else if (tb_load) begin
      mem[tb_load_idx] <= tb_load_val;
    end else if (mem_wr) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end

  dmem_port_arbiter #(
    .DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_func3(ext_func3),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_rd = 1'b0; core_wr = 1'b0; core_addr = 9'h0;
    core_wdata = 32'h0; core_func3 = 3'd2;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 9'h0;
    ext_wdata = 32'h0; ext_func3 = 3'd2;
  endtask

  task automatic load_word(input logic [8:0] addr, input logic [31:0] val);
    tb_load = 1'b1; tb_load_idx = addr[8:2]; tb_load_val = val;
    tick();
    tb_load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; tb_clear = 1'b1; tb_load = 1'b0;
    tb_load_idx = 7'h0; tb_load_val = 32'h0;
    tick();
    tb_clear = 1'b0;
    load_word(9'h010, 32'h11223344);
    load_word(9'h040, 32'h40404040);
    load_word(9'h080, 32'hA5A50001);
    // Core requesting during reset must not reach the memory.
    core_rd = 1'b1; core_wr = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_fail++;
      $display("FAIL reset_mem_en: got rd=%0b wr=%0b want 0 0", mem_rd, mem_wr); end
    n_checks++; if (core_stall !== 1'b0) begin n_fail++;
      $display("FAIL reset_stall: got %0b want 0", core_stall); end
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if ({mem_rd, mem_wr, core_stall, ext_ack} !== 4'b0000) begin n_fail++;
      $display("FAIL post_reset_ctrl: got rd/wr/stall/ack=%b want 0000", {mem_rd, mem_wr, core_stall, ext_ack}); end
    n_checks++; if (ext_rdata !== 32'h0 || core_rdata !== 32'h0 || mem_addr !== 9'h0) begin n_fail++;
      $display("FAIL post_reset_data: got ext_rdata=%h core_rdata=%h mem_addr=%h want 0 0 0", ext_rdata, core_rdata, mem_addr); end
  endtask

  task automatic test_ext_read();
    for (int i = 0; i < 4; i++) tick();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h010;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 9'h010) begin n_fail++;
      $display("FAIL ext_read_grant: got rd=%0b wr=%0b addr=%h want 1 0 010", mem_rd, mem_wr, mem_addr); end
    tick();
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b1 || ext_rdata !== 32'h11223344) begin n_fail++;
      $display("FAIL ext_read_ack: got ack=%0b rdata=%h want 1 11223344", ext_ack, ext_rdata); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++;
      $display("FAIL ext_read_no_regrant: got mem_rd=%0b want 0", mem_rd); end
    tick();
    ext_req = 1'b0;
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b0) begin n_fail++;
      $display("FAIL ext_read_ack_pulse: got %0b want 0", ext_ack); end
    tick();
  endtask

  task automatic test_starvation();
    core_rd = 1'b1; core_addr = 9'h040;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h080;
    for (int c = 0; c < STARVE_LIM; c++) begin
      @(negedge clk);
      n_checks++; if (core_stall !== 1'b0 || mem_addr !== 9'h040 || ext_ack !== 1'b0) begin n_fail++;
        $display("FAIL starve_deny_c%0d: got stall=%0b addr=%h ack=%0b want 0 040 0", c, core_stall, mem_addr, ext_ack); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b1 || mem_addr !== 9'h080 || mem_rd !== 1'b1) begin n_fail++;
      $display("FAIL starve_force: got stall=%0b addr=%h rd=%0b want 1 080 1", core_stall, mem_addr, mem_rd); end
    n_checks++; if (core_rdata !== 32'h0) begin n_fail++;
      $display("FAIL starve_force_core_rdata: got %h want 0", core_rdata); end
    tick();
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b1 || ext_rdata !== 32'hA5A50001) begin n_fail++;
      $display("FAIL starve_ack: got ack=%0b rdata=%h want 1 a5a50001", ext_ack, ext_rdata); end
    n_checks++; if (core_stall !== 1'b0 || mem_addr !== 9'h040 || core_rdata !== 32'h40404040) begin n_fail++;
      $display("FAIL starve_replay: got stall=%0b addr=%h core_rdata=%h want 0 040 40404040", core_stall, mem_addr, core_rdata); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_ext_write_then_load();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h020; ext_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 9'h020 || mem_wdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL ext_write_grant: got wr=%0b rd=%0b addr=%h wdata=%h want 1 0 020 deadbeef", mem_wr, mem_rd, mem_addr, mem_wdata); end
    tick();
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b1 || ext_rdata !== 32'hA5A50001) begin n_fail++;
      $display("FAIL ext_write_ack: got ack=%0b rdata=%h want 1 a5a50001", ext_ack, ext_rdata); end
    tick();
    idle_inputs();
    core_rd = 1'b1; core_addr = 9'h020;
    @(negedge clk);
    n_checks++; if (core_rdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL core_load_after_ext_write: got %h want deadbeef", core_rdata); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_core_gap();
    core_rd = 1'b1; core_addr = 9'h040;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h010;
    tick();
    tick();
    core_rd = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h010 || core_stall !== 1'b0) begin n_fail++;
      $display("FAIL gap_grant: got rd=%0b addr=%h stall=%0b want 1 010 0", mem_rd, mem_addr, core_stall); end
    tick();
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b1 || ext_rdata !== 32'h11223344 || core_stall !== 1'b0) begin n_fail++;
      $display("FAIL gap_ack: got ack=%0b rdata=%h stall=%0b want 1 11223344 0", ext_ack, ext_rdata, core_stall); end
    tick();
    ext_req = 1'b0;
    tick();
    // Back in IDLE: a fresh contested request needs the full count again.
    core_rd = 1'b1; ext_req = 1'b1;
    for (int c = 0; c < STARVE_LIM; c++) begin
      @(negedge clk);
      n_checks++; if (core_stall !== 1'b0) begin n_fail++;
        $display("FAIL gap_recount_c%0d: got stall=%0b want 0", c, core_stall); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b1) begin n_fail++;
      $display("FAIL gap_recount_force: got stall=%0b want 1", core_stall); end
    tick();
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_force();
    core_wr = 1'b1; core_addr = 9'h048; core_wdata = 32'h12345678;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h04C; ext_wdata = 32'hCAFEF00D;
    for (int c = 0; c < STARVE_LIM; c++) tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b0 || core_stall !== 1'b0) begin n_fail++;
      $display("FAIL rst_force_outputs: got wr=%0b stall=%0b want 0 0", mem_wr, core_stall); end
    tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b0 || core_stall !== 1'b0) begin n_fail++;
      $display("FAIL rst_force_no_ack: got ack=%0b stall=%0b want 0 0", ext_ack, core_stall); end
    n_checks++; if (mem[9'h04C >> 2] !== 32'h0 || mem[9'h048 >> 2] !== 32'h12345678) begin n_fail++;
      $display("FAIL rst_force_mem: got [04c]=%h [048]=%h want 0 12345678", mem[9'h04C >> 2], mem[9'h048 >> 2]); end
    tick();
  endtask

  task automatic test_req_drop();
    core_rd = 1'b1; core_addr = 9'h040;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h010;
    tick();
    tick();
    ext_req = 1'b0;
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b0 || ext_ack !== 1'b0) begin n_fail++;
      $display("FAIL drop_quiet: got stall=%0b ack=%0b want 0 0", core_stall, ext_ack); end
    tick();
    ext_req = 1'b1;
    for (int c = 0; c < STARVE_LIM; c++) begin
      @(negedge clk);
      n_checks++; if (core_stall !== 1'b0) begin n_fail++;
        $display("FAIL drop_recount_c%0d: got stall=%0b want 0", c, core_stall); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b1 || mem_addr !== 9'h010) begin n_fail++;
      $display("FAIL drop_force: got stall=%0b addr=%h want 1 010", core_stall, mem_addr); end
    tick();
    @(negedge clk);
    n_checks++; if (ext_ack !== 1'b1 || ext_rdata !== 32'h11223344) begin n_fail++;
      $display("FAIL drop_ack: got ack=%0b rdata=%h want 1 11223344", ext_ack, ext_rdata); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_ext_read();
    test_starvation();
    test_ext_write_then_load();
    test_core_gap();
    test_reset_in_force();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single data-memory port between the pipeline's MEM stage (core) and an external loader/debug requester (ext). The core has priority; ext gets idle cycles, and a starvation counter steals one cycle from the core via `core_stall` after a bounded wait. The arbiter sits between the EX/MEM pipeline register outputs and `datamemory`, and drives the memory's read, write, address, data and func3 inputs.

## Interface
Parameters:
- DATA_W, 32, data width
- DM_ADDRESS, 9, memory byte-address width
- STARVE_LIM, 4, consecutive ext denials before a forced grant; must be ≥2
- CNT_W, $clog2(STARVE_LIM)+1, wait-counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- core_rd  in  1  MEM-stage read enable
- core_wr  in  1  MEM-stage write enable
- core_addr  in  DM_ADDRESS  MEM-stage address
- core_wdata  in  DATA_W  MEM-stage store data
- core_func3  in  3  load/store size code
- core_rdata  out  DATA_W  load data to MEM/WB
- core_stall  out  1  freeze whole pipeline this cycle
- ext_req  in  1  ext access request, held until ext_ack
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  DM_ADDRESS  ext address
- ext_wdata  in  DATA_W  ext write data
- ext_func3  in  3  ext size code
- ext_ack  out  1  one-cycle completion pulse
- ext_rdata  out  DATA_W  ext read data, valid with ext_ack
- mem_rd, mem_wr  out  1 each  to datamemory
- mem_addr  out  DM_ADDRESS  to datamemory
- mem_wdata  out  DATA_W  to datamemory
- mem_func3  out  3  to datamemory
- mem_rdata  in  DATA_W  from datamemory, combinational read

## Operation
- core_active = core_rd | core_wr.
- ext_elig = ext_req & ~ext_ack. A request is never serviced in its own ack cycle.
- Owner per cycle:
  - ext if state==FORCE, or (ext_elig & ~core_active);
  - otherwise core.
- mem_* outputs mux from the owner. When the owner is ext, mem_rd = ~ext_we and mem_wr = ext_we.
- core_rdata = mem_rdata when core owns the port, else 0.
- Ext service: in the grant cycle, capture ext_rdata ← mem_rdata (reads only; writes leave ext_rdata unchanged) and set ext_ack = 1 in the next cycle.
- A denial is a cycle with ext_elig & core_active while the state is not FORCE.
- States:
  - IDLE: on denial → WAIT with cnt=1. Otherwise stay in IDLE with cnt=0.
  - WAIT:
    - ext granted (core idle) → IDLE, cnt=0.
    - ext_req dropped → IDLE, cnt=0.
    - denial with cnt==STARVE_LIM-1 → FORCE.
    - any other denial → cnt+1.
  - FORCE: ext owns the port and core_stall=1 regardless of core_active. Always → IDLE, cnt=0 next cycle.
- core_stall = 1 only in FORCE. During a stall the core must hold its MEM-stage request unchanged, and it is replayed next cycle.
- While reset is high: mem_rd = mem_wr = 0 and core_stall = 0.

## Timing
- Reset values: state IDLE, cnt 0, ext_ack 0, ext_rdata 0. core_stall and mem_rd/mem_wr read 0 in the cycle after reset deasserts, unless inputs request access.
- Core path is combinational, zero added latency: core→mem_* and mem_rdata→core_rdata.
- ext_ack is registered, 1 cycle after the grant cycle.
- ext_rdata holds its value until the next read grant.
- Minimum ext latency: req in cycle t with core idle → ack in t+1.
- Maximum ext latency: ack in t+STARVE_LIM+1, with grant in t+STARVE_LIM.
- Maximum ext throughput: one access per 2 cycles.
- Simultaneous core and ext requests outside FORCE: core wins.
- Reset mid-operation: a pending or granted ext access is dropped, and no ack is issued.
- A write performed in the grant cycle before reset rises is not undone.

## Test plan
- Reset, then no requests:
  - all outputs 0;
  - ext_req=1 read addr 0x010 with core idle in cycle 5 → mem_rd=1, mem_addr=0x010 in cycle 5; ext_ack=1 and ext_rdata=mem word in cycle 6; no grant in cycle 6.
- Core continuously active with ext_req held, STARVE_LIM=4, req from cycle 0:
  - core_stall=0 in cycles 0–3;
  - core_stall=1 and mem_addr=ext_addr in cycle 4;
  - ext_ack in cycle 5;
  - core owns in cycle 5 with the same replayed address.
- Ext write 0xDEADBEEF to 0x020 in a core-idle gap, then core load from 0x020 → core_rdata=0xDEADBEEF.
- Core idle in cycle 2 while ext waits in WAIT (cnt=2) → grant in cycle 2, state returns to IDLE, no stall issued.
- Reset asserted in the FORCE cycle → mem_wr=0, core_stall=0, no ext_ack next cycle, state IDLE.
- ext_req dropped in WAIT → IDLE, cnt=0; a later request restarts the full STARVE_LIM count.
